// File: rtl/pkg_exit_status.sv
// Shared types for the exit-status controller: FSM encoding, exit status codes
// and the APB register map.
package pkg_exit_status;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TMO  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    STATUS_SUCCESS = 2'd0,
    STATUS_FAIL    = 2'd1,
    STATUS_TIMEOUT = 2'd2
  } status_e;

  localparam logic [31:0] OFF_CTRL    = 32'h00;
  localparam logic [31:0] OFF_EXIT    = 32'h04;
  localparam logic [31:0] OFF_TIMEOUT = 32'h08;
  localparam logic [31:0] OFF_CYCLES  = 32'h0C;
  localparam logic [31:0] OFF_STATE   = 32'h10;

  localparam logic [7:0] TMO_EXIT_CODE = 8'hFF;

endpackage

// File: rtl/exit_status_ctrl.sv
// Run/exit status controller: APB register file plus a run FSM that ends in a
// sticky PASS, FAIL or TMO verdict.
module exit_status_ctrl
  import pkg_exit_status::*;
#(
  parameter logic [31:0] TIMEOUT_RST    = 32'd0,
  parameter int          APB_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [31:0]               pwdata_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      done_o,
  output logic [1:0]                status_o,
  output logic [7:0]                exit_code_o
);

  // APB handshake: a transfer completes in the access phase (psel & penable);
  // pready is always 1, so every access phase is exactly one cycle long.
  state_e      state_q, state_d;
  logic [31:0] cycles_q, cycles_d;
  logic [7:0]  code_q, code_d;
  logic [31:0] timeout_q;

  logic [31:0] addr;
  logic        access, wr;
  logic        ctrl_wr, exit_wr, tmo_wr;
  logic        clr_req, start_req, exit_req, tmo_hit;
  logic        addr_hit;
  logic [7:0]  wr_code;
  state_e      verdict;

  assign addr    = 32'(paddr_i);
  assign access  = psel_i & penable_i;
  assign wr      = access & pwrite_i;
  assign ctrl_wr = wr && (addr == OFF_CTRL);
  assign exit_wr = wr && (addr == OFF_EXIT);
  assign tmo_wr  = wr && (addr == OFF_TIMEOUT);

  assign clr_req   = ctrl_wr & pwdata_i[1];
  assign start_req = start_i | (ctrl_wr & pwdata_i[0]);
  assign exit_req  = exit_wr & pwdata_i[31];
  assign wr_code   = pwdata_i[7:0];
  assign verdict   = (wr_code == 8'd0) ? ST_PASS : ST_FAIL;

  // Compares against the registered TIMEOUT, so a new value takes effect one
  // cycle after it is written.
  assign tmo_hit = (timeout_q != 32'd0) && (cycles_q == timeout_q - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cycles_q <= 32'd0;
      code_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      code_q   <= code_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= TIMEOUT_RST;
    end else if (tmo_wr) begin
      timeout_q <= pwdata_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    code_d   = code_q;
    case (state_q)
      ST_IDLE: begin
        if (exit_req) begin
          code_d  = wr_code;
          state_d = verdict;
        end else if (start_req) begin
          state_d  = ST_RUN;
          cycles_d = 32'd0;
        end
      end
      ST_RUN: begin
        cycles_d = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
        // An EXIT write beats a timeout landing on the same edge.
        if (exit_req) begin
          code_d  = wr_code;
          state_d = verdict;
        end else if (tmo_hit) begin
          code_d  = TMO_EXIT_CODE;
          state_d = ST_TMO;
        end
      end
      default: ;
    endcase
    if (clr_req) begin
      state_d  = ST_IDLE;
      cycles_d = 32'd0;
      code_d   = 8'd0;
    end
  end

  always_comb begin
    done_o   = 1'b0;
    status_o = STATUS_SUCCESS;
    case (state_q)
      ST_PASS: begin done_o = 1'b1; status_o = STATUS_SUCCESS; end
      ST_FAIL: begin done_o = 1'b1; status_o = STATUS_FAIL;    end
      ST_TMO:  begin done_o = 1'b1; status_o = STATUS_TIMEOUT; end
      default: ;
    endcase
  end

  always_comb begin
    prdata_o = 32'd0;
    addr_hit = 1'b1;
    case (addr)
      OFF_CTRL:    prdata_o = 32'd0;
      OFF_EXIT:    prdata_o = {done_o, 23'd0, code_q};
      OFF_TIMEOUT: prdata_o = timeout_q;
      OFF_CYCLES:  prdata_o = cycles_q;
      OFF_STATE:   prdata_o = {29'd0, state_q};
      default:     addr_hit = 1'b0;
    endcase
  end

  assign pready_o    = 1'b1;
  assign pslverr_o   = access & ~addr_hit;
  assign exit_code_o = code_q;

endmodule
